// File: rtl/entropy_sample_ctrl_if.sv
// Reader-side handshake for completed entropy words: data/valid from the collector, ack back.
interface entropy_sample_ctrl_if;
    logic [31:0] data;
    logic        data_valid;
    logic        data_ack;

    modport master (
        output data,
        output data_valid,
        input  data_ack
    );

    modport slave (
        input  data,
        input  data_valid,
        output data_ack
    );
endinterface

// File: rtl/entropy_sample_ctrl.sv
// Noise-pin sampler: synchronizes, prescales, optionally von Neumann debiases and packs bits into
// 32-bit words, with a continuous repetition-count health test gating collection.
module entropy_sample_ctrl #(
    parameter int unsigned SAMPLE_DIV = 16,
    parameter int unsigned REP_LIMIT  = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         debias_en,
    input  logic                         noise,
    entropy_sample_ctrl_if.master        rd,
    output logic                         rep_error,
    input  logic                         error_clear,
    output logic [7:0]                   debug
);

    localparam logic [15:0] PrescMax = 16'(SAMPLE_DIV - 1);
    localparam logic [7:0]  RepLimit = 8'(REP_LIMIT);

    typedef enum logic [1:0] {StIdle, StCollect, StFull} state_e;

    state_e      state_q, state_d;
    logic [1:0]  sync_q, sync_d;
    logic [15:0] presc_q, presc_d;
    logic [30:0] shift_q, shift_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic        pair_q, pair_d;
    logic        pair_first_q, pair_first_d;
    logic        mode_q, mode_d;
    logic        prev_q, prev_d;
    logic        have_prev_q, have_prev_d;
    logic [7:0]  rep_cnt_q, rep_cnt_d;
    logic        rep_err_q, rep_err_d;
    logic [31:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic [7:0]  dbg_q, dbg_d;

    logic        sample;
    logic        strobe;
    logic [7:0]  rep_next;
    logic        rep_trip;
    logic        accept;
    logic        bit_val;
    logic        word_done;
    logic        ack_seen;

    // Sample strobe, health-test count and bit acceptance for the current cycle
    always_comb begin
        sample   = sync_q[1];
        strobe   = (state_q != StIdle) && (presc_q == PrescMax);
        ack_seen = (state_q == StFull) && valid_q && rd.data_ack;
        if (have_prev_q && (sample == prev_q)) begin
            rep_next = (rep_cnt_q == 8'hff) ? 8'hff : rep_cnt_q + 8'd1;
        end else begin
            rep_next = 8'd1;
        end
        rep_trip = strobe && (rep_next >= RepLimit);
        accept   = 1'b0;
        bit_val  = sample;
        if ((state_q == StCollect) && enable && strobe && !rep_err_q) begin
            if (!mode_q) begin
                accept = 1'b1;
            end else if (pair_q && (pair_first_q != sample)) begin
                accept  = 1'b1;
                bit_val = pair_first_q;
            end
        end
        word_done = accept && (bit_cnt_q == 5'd31);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (enable) state_d = StCollect;
            end
            StCollect: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (word_done) begin
                    state_d = StFull;
                end
            end
            StFull: begin
                if (ack_seen) state_d = enable ? StCollect : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        sync_d       = {sync_q[0], noise};
        presc_d      = presc_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        pair_d       = pair_q;
        pair_first_d = pair_first_q;
        mode_d       = mode_q;
        prev_d       = prev_q;
        have_prev_d  = have_prev_q;
        rep_cnt_d    = rep_cnt_q;
        rep_err_d    = rep_err_q;
        data_d       = data_q;
        valid_d      = valid_q;
        dbg_d        = dbg_q;

        // Prescaler phase survives FULL; it only restarts through IDLE
        if ((state_q == StIdle) || ((state_q == StCollect) && !enable) || strobe) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + 16'd1;
        end

        if (state_q == StIdle) have_prev_d = 1'b0;
        if (strobe) begin
            rep_cnt_d   = rep_next;
            prev_d      = sample;
            have_prev_d = 1'b1;
        end else if (error_clear) begin
            rep_cnt_d = '0;
        end
        if (rep_trip) begin
            rep_err_d = 1'b1;
        end else if (error_clear) begin
            rep_err_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                bit_cnt_d = '0;
                pair_d    = 1'b0;
                mode_d    = debias_en;
            end
            StCollect: begin
                if (!enable) begin
                    bit_cnt_d = '0;
                    pair_d    = 1'b0;
                end else if (strobe && !rep_err_q && mode_q) begin
                    pair_d = !pair_q;
                    if (!pair_q) pair_first_d = sample;
                end
            end
            StFull: begin
                if (ack_seen && enable) begin
                    bit_cnt_d = '0;
                    pair_d    = 1'b0;
                    mode_d    = debias_en;
                end
            end
            default: begin
            end
        endcase

        if (accept) begin
            shift_d   = {shift_q[29:0], bit_val};
            bit_cnt_d = bit_cnt_q + 5'd1;
        end
        if (word_done) begin
            data_d  = {shift_q, bit_val};
            valid_d = 1'b1;
            dbg_d   = dbg_q + 8'd1;
        end
        if (ack_seen) valid_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q       <= '0;
            presc_q      <= '0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            pair_q       <= 1'b0;
            pair_first_q <= 1'b0;
            mode_q       <= 1'b0;
            prev_q       <= 1'b0;
            have_prev_q  <= 1'b0;
            rep_cnt_q    <= '0;
            rep_err_q    <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            dbg_q        <= '0;
        end else begin
            sync_q       <= sync_d;
            presc_q      <= presc_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            pair_q       <= pair_d;
            pair_first_q <= pair_first_d;
            mode_q       <= mode_d;
            prev_q       <= prev_d;
            have_prev_q  <= have_prev_d;
            rep_cnt_q    <= rep_cnt_d;
            rep_err_q    <= rep_err_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            dbg_q        <= dbg_d;
        end
    end

    always_comb begin
        rd.data       = data_q;
        rd.data_valid = valid_q;
        rep_error     = rep_err_q;
        debug         = dbg_q;
    end

endmodule

// File: tb/tb_entropy_sample_ctrl.sv
// Directed bench for entropy_sample_ctrl: noise driven one value per sample slot, completed words
// checked by a scoreboard monitor on each rising data_valid.
module tb_entropy_sample_ctrl;

    localparam int SD = 4;
    localparam int RL = 32;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  dbg;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        debias_en = 1'b0;
    logic        noise = 1'b0;
    logic        rep_error;
    logic        error_clear = 1'b0;
    logic [7:0]  debug;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          e0 = 0;
    int          rise_cyc = -1;
    exp_t        exp_q[$];

    entropy_sample_ctrl_if rd_if ();

    entropy_sample_ctrl #(
        .SAMPLE_DIV (SD),
        .REP_LIMIT  (RL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .debias_en   (debias_en),
        .noise       (noise),
        .rd          (rd_if),
        .rep_error   (rep_error),
        .error_clear (error_clear),
        .debug       (debug)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_word(input logic [31:0] d, input logic [7:0] g);
        exp_t e;
        e.data = d;
        e.dbg  = g;
        exp_q.push_back(e);
    endtask

    // One prescaler period; noise is stable around its sampling edge. clr: 1=first cycle, 2=strobe cycle.
    task automatic slot(input logic b, input bit ack, input int clr);
        noise = b;
        for (int i = 0; i < SD; i++) begin
            rd_if.data_ack = ack && (i == 0);
            error_clear    = ((clr == 1) && (i == 0)) || ((clr == 2) && (i == SD - 1));
            @(posedge clk);
            #1;
        end
        rd_if.data_ack = 1'b0;
        error_clear    = 1'b0;
    endtask

    task automatic feed_raw(input logic [31:0] w, input bit ack_first, input bit clr_first);
        for (int i = 31; i >= 0; i--) begin
            slot(w[i], ack_first && (i == 31), (clr_first && (i == 31)) ? 1 : 0);
        end
    endtask

    task automatic start_run(input logic dbe);
        debias_en = dbe;
        enable    = 1'b1;
        @(posedge clk);
        #1;
        e0 = cyc;
    endtask

    task automatic ack_and_stop();
        enable         = 1'b0;
        rd_if.data_ack = 1'b1;
        @(posedge clk);
        #1;
        rd_if.data_ack = 1'b0;
        chk("valid drops after ack", {31'b0, rd_if.data_valid}, 32'd0);
    endtask

    // Scoreboard monitor
    initial begin
        logic prev_valid;
        exp_t e;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rd_if.data_valid && !prev_valid) begin
                rise_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk("unexpected word", rd_if.data, 32'hxxxxxxxx);
                end else begin
                    e = exp_q.pop_front();
                    chk("word data", rd_if.data, e.data);
                    chk("word debug", {24'b0, debug}, {24'b0, e.dbg});
                end
            end
            prev_valid = rd_if.data_valid;
        end
    end

    initial begin
        logic [31:0] x;
        rd_if.data_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset data", rd_if.data, 32'd0);
        chk("reset valid", {31'b0, rd_if.data_valid}, 32'd0);
        chk("reset rep_error", {31'b0, rep_error}, 32'd0);
        chk("reset debug", {24'b0, debug}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Raw word, then long backpressure with toggling noise
        start_run(1'b0);
        expect_word(32'hAAAAAAAA, 8'd1);
        feed_raw(32'hAAAAAAAA, 1'b0, 1'b0);
        for (int i = 0; i < 125; i++) slot((i % 2) == 0, 1'b0, 0);
        chk("valid rise latency", rise_cyc - e0, 32'd128);
        chk("backpressure data", rd_if.data, 32'hAAAAAAAA);
        chk("backpressure valid", {31'b0, rd_if.data_valid}, 32'd1);

        // Ack in the first cycle of a slot: that slot's sample starts the next word
        expect_word(32'h12345678, 8'd2);
        feed_raw(32'h12345678, 1'b1, 1'b0);
        ack_and_stop();

        // Debias: (1,0) pairs -> ones, (0,1) pairs -> zeros
        start_run(1'b1);
        expect_word(32'hFFFFFFFF, 8'd3);
        for (int i = 0; i < 32; i++) begin
            slot(1'b1, 1'b0, 0);
            slot(1'b0, 1'b0, 0);
        end
        expect_word(32'h00000000, 8'd4);
        for (int i = 0; i < 32; i++) begin
            slot(1'b0, i == 0, 0);
            slot(1'b1, 1'b0, 0);
        end

        // Debias with discarded (1,1) and (0,0) pairs interleaved
        x = 32'hA5C39E01;
        expect_word(x, 8'd5);
        for (int i = 31; i >= 0; i--) begin
            slot(1'b1, i == 31, 0);
            slot(1'b1, 1'b0, 0);
            slot(x[i], 1'b0, 0);
            slot(!x[i], 1'b0, 0);
            slot(1'b0, 1'b0, 0);
            slot(1'b0, 1'b0, 0);
        end
        ack_and_stop();

        // Drop enable after 10 bits; the following word holds only new bits
        start_run(1'b0);
        for (int i = 0; i < 10; i++) slot(1'b1, 1'b0, 0);
        enable = 1'b0;
        @(posedge clk);
        #1;
        chk("no word after drop", {31'b0, rd_if.data_valid}, 32'd0);
        start_run(1'b0);
        expect_word(32'h0F0F5A5A, 8'd6);
        feed_raw(32'h0F0F5A5A, 1'b0, 1'b0);
        ack_and_stop();

        // Health test: constant noise trips on the 32nd strobe, whose bit is still accepted
        start_run(1'b0);
        expect_word(32'hFFFFFFFF, 8'd7);
        for (int i = 0; i < 31; i++) slot(1'b1, 1'b0, 0);
        chk("rep_error before trip", {31'b0, rep_error}, 32'd0);
        slot(1'b1, 1'b0, 0);
        chk("rep_error at trip", {31'b0, rep_error}, 32'd1);
        enable = 1'b1;
        for (int i = 0; i < 41; i++) slot(1'b1, i == 0, 0);
        chk("stalled no word", {31'b0, rd_if.data_valid}, 32'd0);
        chk("rep_error sticky", {31'b0, rep_error}, 32'd1);
        expect_word(32'h6C6C3938, 8'd8);
        feed_raw(32'h6C6C3938, 1'b0, 1'b1);
        chk("rep_error cleared", {31'b0, rep_error}, 32'd0);

        // error_clear on the tripping strobe: set wins
        expect_word(32'hFFFFFFFF, 8'd9);
        for (int i = 0; i < 31; i++) slot(1'b1, i == 0, 0);
        chk("rep_error before coincident", {31'b0, rep_error}, 32'd0);
        slot(1'b1, 1'b0, 2);
        chk("rep_error set wins", {31'b0, rep_error}, 32'd1);
        chk("valid before reset", {31'b0, rd_if.data_valid}, 32'd1);

        // Reset while FULL
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("post-reset data", rd_if.data, 32'd0);
        chk("post-reset valid", {31'b0, rd_if.data_valid}, 32'd0);
        chk("post-reset debug", {24'b0, debug}, 32'd0);
        chk("post-reset rep_error", {31'b0, rep_error}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
